// File: rtl/serial_word_framer.sv
// Serial word framer: deserializes strobed start/data/parity/stop frames into 5-bit words,
// queues them in a small FIFO and presents the head word with valid/ack handshake and sticky flags.
module serial_word_framer #(
  parameter int PARITY_EN = 1,
  parameter int DEPTH     = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic clk, rst_n, sdata, strobe, ack, clr;
  logic unused_in;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign sdata     = io_in[2];
  assign strobe    = io_in[3];
  assign ack       = io_in[4];
  assign clr       = io_in[5];
  assign unused_in = &{1'b0, io_in[7:6]};

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [4:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           par_ok, push_d, bad;
  logic           push_q;
  logic [4:0]     pword_q;

  logic [4:0]     mem_q [DEPTH];
  logic [4:0]     mem_d [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ack_q, ack_rise, pop, full, do_push, overrun;
  logic [4:0]     word_q, word_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d, ovr_q, ovr_d;

  // Frame receiver FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign par_ok = (PARITY_EN == 0) || (^{shift_q, par_q} == 1'b0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    push_d  = 1'b0;
    bad     = 1'b0;
    if (strobe) begin
      case (state_q)
        IDLE: begin
          if (sdata) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d[cnt_q] = sdata;
          if (cnt_q == 3'd4) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          else               cnt_d   = cnt_q + 3'd1;
        end
        PARITY: begin
          par_d   = sdata;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!sdata && par_ok) push_d = 1'b1;
          else                  bad    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      push_q  <= 1'b0;
      pword_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      push_q  <= push_d;
      if (push_d) pword_q <= shift_q;
    end
  end

  // FIFO next state; head word and valid are registered from the post-update contents
  assign ack_rise = ack && !ack_q;
  assign pop      = ack_rise && valid_q;
  assign full     = (count_q == CW'(DEPTH));
  assign do_push  = push_q && (!full || pop);
  assign overrun  = push_q && full && !pop;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = pword_q;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(pop);
    valid_d = (count_d != '0);
    word_d  = valid_d ? mem_d[rd_d] : '0;
    err_d   = bad     ? 1'b1 : (clr ? 1'b0 : err_q);
    ovr_d   = overrun ? 1'b1 : (clr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ack_q   <= ack;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign io_out = {ovr_q, err_q, valid_q, word_q};

endmodule

// File: tb/tb_serial_word_framer.sv
// Directed bench for serial_word_framer (PARITY_EN=1, DEPTH=2); io_out = {ovr, err, valid, word}.
module tb_serial_word_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sdata = 1'b0, strobe = 1'b0, ack = 1'b0, clr = 1'b0;
  logic [1:0] spare = 2'b00;
  logic [7:0] io_in, io_out, exp_v;
  int         errors = 0;
  int         checks = 0;

  assign io_in = {spare, clr, ack, strobe, sdata, rst_n, clk};

  serial_word_framer #(.PARITY_EN(1), .DEPTH(2)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  // Sends a frame, first bit = seq[7]; returns at the negedge after the stop-bit edge with strobe low.
  task automatic send8(input logic [7:0] seq);
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      sdata  = seq[7-i];
      strobe = 1'b1;
    end
    @(negedge clk);
    strobe = 1'b0;
    sdata  = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; strobe = 1'b0; sdata = 1'b0; ack = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    exp_v = 8'h00; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL reset_assert: got %h expected %h", io_out, exp_v); end
    spare = 2'b11;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sdata = 1'b1;
    repeat (3) @(negedge clk);
    exp_v = 8'h00; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL reset_idle: got %h expected %h", io_out, exp_v); end
    spare = 2'b00; sdata = 1'b0;
    ack_pulse();
    @(negedge clk);
    exp_v = 8'h00; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL ack_when_empty: got %h expected %h", io_out, exp_v); end
  endtask

  task automatic test_single_frame();
    do_reset();
    send8(8'b10110110);
    exp_v = 8'h00; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL single_latency: got %h expected %h", io_out, exp_v); end
    @(negedge clk);
    exp_v = {3'b001, 5'b10110}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL single_frame: got %h expected %h", io_out, exp_v); end
  endtask

  task automatic test_parity_error();
    do_reset();
    send8(8'b10110100);
    @(negedge clk);
    exp_v = {3'b010, 5'b00000}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL parity_err: got %h expected %h", io_out, exp_v); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_v = 8'h00; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL parity_clr: got %h expected %h", io_out, exp_v); end
  endtask

  task automatic test_stop_error();
    do_reset();
    send8(8'b10110111);
    @(negedge clk);
    exp_v = {3'b010, 5'b00000}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL stop_err: got %h expected %h", io_out, exp_v); end
    send8(8'b11000010);
    @(negedge clk);
    exp_v = {3'b011, 5'b00001}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL stop_then_good: got %h expected %h", io_out, exp_v); end
  endtask

  task automatic test_overrun();
    do_reset();
    send8(8'b11100000);
    send8(8'b10011110);
    send8(8'b11010110);
    @(negedge clk);
    exp_v = {3'b101, 5'h03}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL ovr_head: got %h expected %h", io_out, exp_v); end
    ack_pulse();
    exp_v = {3'b101, 5'h1C}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL ovr_pop1: got %h expected %h", io_out, exp_v); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_v = {3'b001, 5'h1C}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL ovr_clr: got %h expected %h", io_out, exp_v); end
    ack_pulse();
    exp_v = 8'h00; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL ovr_pop2: got %h expected %h", io_out, exp_v); end
  endtask

  task automatic test_strobe_gap();
    logic [7:0] seq;
    do_reset();
    seq = 8'b10110110;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      sdata  = seq[7-i];
      strobe = 1'b1;
      for (int unsigned g = 0; g < 1 + (i % 3); g++) begin
        @(negedge clk);
        strobe = 1'b0;
        sdata  = 1'($urandom_range(1, 0));
        spare  = 2'($urandom_range(3, 0));
      end
    end
    strobe = 1'b0; sdata = 1'b0; spare = 2'b00;
    @(negedge clk);
    exp_v = {3'b001, 5'b10110}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL gap_frame: got %h expected %h", io_out, exp_v); end
    send8(8'b11000010);
    @(negedge clk);
    exp_v = {3'b001, 5'b10110}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL gap_second_queued: got %h expected %h", io_out, exp_v); end
    @(negedge clk);
    ack = 1'b1;
    repeat (5) @(negedge clk);
    ack = 1'b0;
    exp_v = {3'b001, 5'b00001}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL ack_hold_one_pop: got %h expected %h", io_out, exp_v); end
    ack_pulse();
    exp_v = 8'h00; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL ack_hold_drain: got %h expected %h", io_out, exp_v); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send8(8'b10110110);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    exp_v = {3'b001, 5'b10110}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL push_pop_empty: got %h expected %h", io_out, exp_v); end
    send8(8'b10011110);
    @(negedge clk);
    send8(8'b11010110);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    exp_v = {3'b001, 5'h1C}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL push_pop_full: got %h expected %h", io_out, exp_v); end
    ack_pulse();
    exp_v = {3'b001, 5'h15}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL b2b_pop1: got %h expected %h", io_out, exp_v); end
    ack_pulse();
    exp_v = 8'h00; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL b2b_pop2: got %h expected %h", io_out, exp_v); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send8(8'b11100000);
    send8(8'b10110100);
    @(negedge clk);
    exp_v = {3'b011, 5'h03}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL pre_reset: got %h expected %h", io_out, exp_v); end
    @(negedge clk); sdata = 1'b1; strobe = 1'b1;
    @(negedge clk); sdata = 1'b1;
    @(negedge clk); sdata = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    exp_v = 8'h00; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL async_reset: got %h expected %h", io_out, exp_v); end
    strobe = 1'b0; sdata = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send8(8'b10101000);
    @(negedge clk);
    exp_v = {3'b001, 5'h0A}; checks++;
    if (io_out !== exp_v) begin errors++; $display("FAIL post_reset_frame: got %h expected %h", io_out, exp_v); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_error();
    test_stop_error();
    test_overrun();
    test_strobe_gap();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_framer.md
Name: serial_word_framer

Overview:
- Upstream input stage for the 5-bit combinational code transform.
- Deserializes framed serial data sampled on a strobe and checks parity and stop bits.
- Buffers received 5-bit words in a small FIFO and presents the head word on io_out[4:0], held stable, so the transform can consume it directly.
- Uses a valid/acknowledge handshake and reports sticky error and overrun status.

Parameters:
- PARITY_EN, 1: 1 = frame carries an even-parity bit; 0 = no parity bit (frame has 7 bits).
- DEPTH, 2: FIFO depth in words; legal values 2 or 4.

Ports:
- io_in[0]  input  1  clk; the single clock, rising edge.
- io_in[1]  input  1  rst_n; asynchronous, active-low reset.
- io_in[2]  input  1  sdata; serial data bit.
- io_in[3]  input  1  strobe; sdata is sampled on a clk edge only while strobe=1.
- io_in[4]  input  1  ack; the consumer takes the head word on an ack rising edge.
- io_in[5]  input  1  clr; level, synchronous; clears the sticky err and ovr flags.
- io_in[7:6]  input  2  unused; ignored.
- io_out[4:0]  output  5  word; FIFO head, 0 when the FIFO is empty.
- io_out[5]  output  1  valid; FIFO non-empty.
- io_out[6]  output  1  err; sticky parity or stop-bit error.
- io_out[7]  output  1  ovr; sticky overrun.

Behaviour:
- Interface: one clock (io_in[0]); reset is asynchronous and active-low (io_in[1]).
- Reset: FSM=IDLE, FIFO empty, pointers=0, word=0, valid=0, err=0, ovr=0, ack edge register=0.
- Reset mid-frame aborts the frame and discards any partial data.
- Frame, LSB first: start bit (1), d0..d4, parity bit (PARITY_EN=1 only), stop bit (0).
- Even parity: the count of ones across d0..d4 plus the parity bit is even.
- FSM, advancing only on clk edges where strobe=1:
  - IDLE: sdata=1 -> DATA with bit counter=0; sdata=0 -> stay in IDLE.
  - DATA: shift sdata into bit[counter]; on counter=4 -> PARITY if PARITY_EN, else STOP.
  - PARITY: latch the parity bit -> STOP.
  - STOP: sample the stop bit -> IDLE.
- Word check, done in STOP:
  - Word good if stop=0 and parity is correct (or PARITY_EN=0).
  - Good word: push to the FIFO.
  - Bad word: discard and set err.
- Latency: word and valid update on the clk edge after the stop-bit sample edge; the push is registered, and io_out is driven from registers only.
- ack handling:
  - A rising edge is ack=1 this cycle with ack=0 registered the previous cycle.
  - On a rising edge with valid=1: pop; the next entry (or 0) appears the following cycle.
  - A rising edge with valid=0 is ignored.
  - ack held high pops only once.
- Simultaneous push and pop:
  - When full: both occur, and the count stays DEPTH.
  - When empty: the pushed word becomes the head; the pop is ignored because valid was 0.
- Push when full with no pop: the new word is dropped, ovr is set, and the FIFO contents are unchanged.
- Flag clearing: clr=1 clears err and ovr on the next edge.
  - If clr coincides with a set event, the set wins.
  - FIFO contents are unaffected.
- Wrap-around: read and write pointers are modulo DEPTH; count width is clog2(DEPTH)+1.
- strobe=0: FSM, counter and shift register hold. The FIFO and the ack logic still run every clk.
- Unused inputs must not affect any output.

Test Plan:
- Single frame: reset, then with strobe=1 send 1,0,1,1,0,1,1,0 -> one cycle after the stop edge: word=5'b10110, valid=1, err=0.
- Parity error: same frame with parity=0 -> valid stays 0, err=1; then clr=1 for 1 cycle -> err=0.
- Stop error: a frame with stop bit=1 -> word discarded, err=1.
  - Then send a valid frame for 5'b00001 (1,1,0,0,0,0,1,0) -> word=5'b00001.
- FIFO order and overrun (DEPTH=2): send 5'h03, 5'h1C, 5'h15 with no ack.
  - Required: word=5'h03, ovr=1.
  - ack pulse -> 5'h1C; ack pulse -> 0 with valid=0 (5'h15 was dropped).
- Strobe gating and ack edge:
  - Interleave strobe=0 gaps inside a frame -> same result as an ungapped frame.
  - Hold ack=1 for 5 cycles -> exactly one pop.
- Async reset: assert rst_n=0 mid-frame, asynchronously to clk -> all outputs go to 0 immediately.
  - After release, a full frame 5'h0A is received correctly.
